// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Brief    : UART transmit serializer on the RX oversampling clock. Each
//            frame is a start bit, DATA_WIDTH data bits (LSB first), an
//            optional parity bit and a stop bit. Every bit is held for
//            prescale+1 CLK cycles. Define UART_TX_TWO_STOP_EN to send two
//            stop bits instead of one.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      TX_OUT,
    output logic                      busy
);

    localparam int c_IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_WIDTH - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]                r_state;
    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [c_IDX_W-1:0]        r_idx;
    logic [DATA_WIDTH-1:0]     r_data;
    logic                      r_par_en;
    logic                      r_par_typ;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic                      r_tx_out;
    logic                      r_busy;
`ifdef UART_TX_TWO_STOP_EN
    logic                      r_stop2;
    logic                      w_stop2_nxt;
`endif

    logic [2:0]                w_state_nxt;
    logic [PRESCALE_WIDTH-1:0] w_cnt_nxt;
    logic [c_IDX_W-1:0]        w_idx_nxt;
    logic                      w_accept;
    logic                      w_bit_done;
    logic                      w_parity;
    logic                      w_tx_nxt;
    logic                      w_busy_nxt;

    // A bit period ends when the counter reaches the latched prescale.
    assign w_bit_done = (r_cnt == r_prescale);
    // Even parity is the XOR of the data; odd parity is its inverse.
    assign w_parity   = (^r_data) ^ r_par_typ;

    // Next-state, bit-period counter and bit-index logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_accept    = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        w_stop2_nxt = r_stop2;
`endif
        case (r_state)
            c_IDLE: begin
                if (Data_Valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_START;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            c_START: begin
                if (w_bit_done) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = c_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + PRESCALE_WIDTH'(1);
                end
            end
            c_DATA: begin
                if (w_bit_done) begin
                    w_cnt_nxt = '0;
                    if (r_idx == c_LAST_IDX) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = r_par_en ? c_PARITY : c_STOP;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + PRESCALE_WIDTH'(1);
                end
            end
            c_PARITY: begin
                if (w_bit_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + PRESCALE_WIDTH'(1);
                end
            end
            c_STOP: begin
                if (w_bit_done) begin
                    w_cnt_nxt = '0;
`ifdef UART_TX_TWO_STOP_EN
                    // First stop period done: stay for a second one.
                    if (!r_stop2) begin
                        w_stop2_nxt = 1'b1;
                    end else begin
                        w_stop2_nxt = 1'b0;
                        w_state_nxt = c_IDLE;
                    end
`else
                    w_state_nxt = c_IDLE;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + PRESCALE_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Line level for the upcoming cycle, so TX_OUT can be a plain register.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            c_START:  w_tx_nxt = 1'b0;
            c_DATA:   w_tx_nxt = r_data[w_idx_nxt];
            c_PARITY: w_tx_nxt = w_parity;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    assign w_busy_nxt = (w_state_nxt != c_IDLE);

    // FSM, counters and registered outputs; reset aborts any frame at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_tx_out <= 1'b1;
            r_busy   <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            r_stop2  <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_tx_out <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
`ifdef UART_TX_TWO_STOP_EN
            r_stop2  <= w_stop2_nxt;
`endif
        end
    end

    // Frame configuration is captured only on accept and held for the frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_prescale <= '0;
        end else if (w_accept) begin
            r_data     <= P_DATA;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_prescale <= prescale;
        end
    end

    assign TX_OUT = r_tx_out;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_serializer
// Brief    : Directed self-checking bench for uart_tx_serializer.
//            Define UART_TX_TWO_STOP_EN to exercise the two-stop-bit build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOPS = 2;
`else
    localparam int STOPS = 1;
`endif

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [4:0] prescale;
    logic       TX_OUT;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    logic cap_tx   [0:1023];
    logic cap_busy [0:1023];

    uart_tx_serializer #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (5)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // head[0] is the start bit, then data LSB first, then parity if present;
    // anything past nhead is stop / idle level.
    function automatic logic exp_line(input logic [9:0] head, input int nhead,
                                      input int p, input int idx);
        int b;
        b = idx / (p + 1);
        return (b < nhead) ? head[b] : 1'b1;
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [4:0] p,
                             input logic [9:0] head, input int nhead, input int inject_at);
        int n;
        int exp_busy;
        @(negedge CLK);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = p; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        chk($sformatf("%s latency_busy", tag), busy, 1'b1);
        chk($sformatf("%s latency_start", tag), TX_OUT, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            cap_tx[n] = TX_OUT;
            if (n == inject_at) begin
                P_DATA = 8'hFF; Data_Valid = 1'b1; PAR_EN = ~pe; prescale = 5'd3;
            end else if (n == inject_at + 1) begin
                Data_Valid = 1'b0;
            end
            n++;
            @(negedge CLK);
        end
        Data_Valid = 1'b0;
        exp_busy = (nhead + STOPS) * (int'(p) + 1);
        chk($sformatf("%s busy_len", tag), n, exp_busy);
        for (int i = 0; i < n && i < exp_busy; i++)
            chk($sformatf("%s tx[%0d]", tag, i), cap_tx[i], exp_line(head, nhead, int'(p), i));
        repeat (4) begin
            chk($sformatf("%s idle_tx", tag), TX_OUT, 1'b1);
            chk($sformatf("%s idle_busy", tag), busy, 1'b0);
            @(negedge CLK);
        end
    endtask

    initial begin
        int L;
        RST = 1'b0; P_DATA = 8'h00; Data_Valid = 1'b0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 5'd7;
        #12;
        chk("reset_tx", TX_OUT, 1'b1);
        chk("reset_busy", busy, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("post_reset_tx", TX_OUT, 1'b1);
        chk("post_reset_busy", busy, 1'b0);

        // 0xA5 = 1010_0101, four ones: even parity 0, odd parity 1.
        run_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 5'd7,  {1'b0, 8'hA5, 1'b0}, 9,  -1);
        run_frame("a5_even",  8'hA5, 1'b1, 1'b0, 5'd7,  {1'b0, 8'hA5, 1'b0}, 10, -1);
        run_frame("a5_odd",   8'hA5, 1'b1, 1'b1, 5'd7,  {1'b1, 8'hA5, 1'b0}, 10, -1);
        // 0x07 has three ones: odd parity bit is 0.
        run_frame("07_odd",   8'h07, 1'b1, 1'b1, 5'd15, {1'b0, 8'h07, 1'b0}, 10, -1);
        // Inputs (including a Data_Valid pulse) change at cycle 20 of the frame.
        run_frame("midchg",   8'h00, 1'b0, 1'b0, 5'd7,  {1'b0, 8'h00, 1'b0}, 9,  20);
        // One cycle per bit.
        run_frame("p0",       8'hA5, 1'b0, 1'b0, 5'd0,  {1'b0, 8'hA5, 1'b0}, 9,  -1);

        // Reset during data bit 3 of an all-zero frame (cycles 32..39).
        @(negedge CLK);
        P_DATA = 8'h00; PAR_EN = 1'b0; prescale = 5'd7; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (34) @(negedge CLK);
        chk("pre_reset_tx", TX_OUT, 1'b0);
        chk("pre_reset_busy", busy, 1'b1);
        #2 RST = 1'b0;
        #1;
        chk("async_reset_tx", TX_OUT, 1'b1);
        chk("async_reset_busy", busy, 1'b0);
        @(negedge CLK);
        #2 RST = 1'b1;
        repeat (20) begin
            @(negedge CLK);
            chk("after_reset_tx", TX_OUT, 1'b1);
            chk("after_reset_busy", busy, 1'b0);
        end

        // Back-to-back with Data_Valid held: 0x55 then 0xAA, prescale 7.
        L = (9 + STOPS) * 8;
        @(negedge CLK);
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 5'd7; Data_Valid = 1'b1;
        @(negedge CLK);
        P_DATA = 8'hAA;
        for (int n = 0; n < 2 * L + 6; n++) begin
            cap_tx[n]   = TX_OUT;
            cap_busy[n] = busy;
            if (n == L + 1) Data_Valid = 1'b0;
            @(negedge CLK);
        end
        for (int i = 0; i < L; i++) begin
            chk($sformatf("b2b_f1 busy[%0d]", i), cap_busy[i], 1'b1);
            chk($sformatf("b2b_f1 tx[%0d]", i), cap_tx[i], exp_line({1'b0, 8'h55, 1'b0}, 9, 7, i));
        end
        chk("b2b_gap_busy", cap_busy[L], 1'b0);
        chk("b2b_gap_tx", cap_tx[L], 1'b1);
        for (int i = 0; i < L; i++) begin
            chk($sformatf("b2b_f2 busy[%0d]", i), cap_busy[L + 1 + i], 1'b1);
            chk($sformatf("b2b_f2 tx[%0d]", i), cap_tx[L + 1 + i],
                exp_line({1'b0, 8'hAA, 1'b0}, 9, 7, i));
        end
        for (int i = 2 * L + 1; i < 2 * L + 6; i++) begin
            chk($sformatf("b2b_end busy[%0d]", i), cap_busy[i], 1'b0);
            chk($sformatf("b2b_end tx[%0d]", i), cap_tx[i], 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
